mod_i2s_serializer: RTL and testbench

- Data stage directly downstream of the I2S timing generator (mod_i2s_tx), which supplies sck/ws.
- Accepts stereo PCM frames from an upstream source over a valid/ready handshake.
- Left-justifies each sample into a SLOT_W-bit slot and drives o_sd in standard Philips I2S format: MSB one sck after each ws edge, data changing on sck falling edges.
- Runs entirely in the i_clk domain; sck and ws are sampled as ordinary registered inputs and need no synchronisers.

---
 rtl/mod_i2s_serializer.sv | 107 ++++++++++
 tb/tb_mod_i2s_serializer.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mod_i2s_serializer.sv
// I2S data serializer: takes stereo PCM frames over valid/ready and shifts them out
// left-justified, Philips format, against the externally generated sck/ws.
module mod_i2s_serializer #(
    parameter int unsigned DATA_W = 24,
    parameter int unsigned SLOT_W = 32
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_sck,
    input  logic              i_ws,
    input  logic [DATA_W-1:0] i_left,
    input  logic [DATA_W-1:0] i_right,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic              i_mute,
    output logic              o_sd,
    output logic              o_underrun
);

    localparam int unsigned PAD_W = SLOT_W - DATA_W;

    logic              sck_q;
    logic              ws_q;
    logic              hold_full;
    logic              hold_mute;
    logic [DATA_W-1:0] hold_left;
    logic [DATA_W-1:0] hold_right;
    logic [SLOT_W-1:0] shreg;
    logic [SLOT_W-1:0] right_reg;

    logic fall;
    logic chg;
    logic load_left;
    logic load_right;
    logic accept;

    // Place a sample in the top DATA_W bits of a slot, zero-filling the LSBs.
    function automatic logic [SLOT_W-1:0] justify(input logic [DATA_W-1:0] s);
        return SLOT_W'(s) << PAD_W;
    endfunction

    // Edge/slot decode; ws_q only tracks ws on falling sck edges.
    always_comb begin
        fall       = 1'b0;
        chg        = 1'b0;
        load_left  = 1'b0;
        load_right = 1'b0;
        accept     = 1'b0;
        fall       = sck_q & ~i_sck;
        chg        = fall & (i_ws != ws_q);
        load_left  = chg & ~i_ws;
        load_right = chg & i_ws;
        accept     = i_valid & ~hold_full;
    end

    assign o_ready = ~hold_full;

    // Edge detect, serial output and slot shift register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sck_q      <= 1'b0;
            ws_q       <= 1'b0;
            o_sd       <= 1'b0;
            o_underrun <= 1'b0;
            shreg      <= '0;
            right_reg  <= '0;
        end else begin
            sck_q      <= i_sck;
            o_underrun <= load_left & ~hold_full;
            if (fall) begin
                ws_q <= i_ws;
                o_sd <= shreg[SLOT_W-1];
                if (load_left) begin
                    if (hold_full && !hold_mute) begin
                        shreg     <= justify(hold_left);
                        right_reg <= justify(hold_right);
                    end else begin
                        shreg     <= '0;
                        right_reg <= '0;
                    end
                end else if (load_right) begin
                    shreg <= right_reg;
                end else begin
                    shreg <= shreg << 1;
                end
            end
        end
    end

    // One-frame holding register; a left-slot load and an accept never coincide.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            hold_full  <= 1'b0;
            hold_mute  <= 1'b0;
            hold_left  <= '0;
            hold_right <= '0;
        end else if (load_left && hold_full) begin
            hold_full <= 1'b0;
        end else if (accept) begin
            hold_full  <= 1'b1;
            hold_mute  <= i_mute;
            hold_left  <= i_left;
            hold_right <= i_right;
        end
    end

endmodule

// File: tb/tb_mod_i2s_serializer.sv
// Self-checking bench for mod_i2s_serializer: slot-level reference model rebuilds
// expected left/right words per frame and compares them with words decoded from o_sd.
module tb_mod_i2s_serializer;

    localparam int unsigned DW         = 24;
    localparam int unsigned SW         = 32;
    localparam int unsigned SCK_DIV    = 4;
    localparam int unsigned FRAME_CLKS = 2 * SW * SCK_DIV;

    typedef enum int {SRC_IDLE, SRC_ONCE, SRC_COUNT, SRC_RAND} src_t;

    logic          i_clk = 1'b0;
    logic          rst, sck, ws, valid, mute;
    logic [DW-1:0] left, right;
    logic          ready, sd, underrun;
    logic [31:0]   left32, right32;
    logic          valid32, mute32;
    logic          ready32, sd32, underrun32;

    always #5 i_clk = ~i_clk;

    mod_i2s_serializer #(.DATA_W(DW), .SLOT_W(SW)) u_dut (
        .i_clk(i_clk), .i_rst(rst), .i_sck(sck), .i_ws(ws),
        .i_left(left), .i_right(right), .i_valid(valid), .o_ready(ready),
        .i_mute(mute), .o_sd(sd), .o_underrun(underrun)
    );

    mod_i2s_serializer #(.DATA_W(32), .SLOT_W(SW)) u_dut32 (
        .i_clk(i_clk), .i_rst(rst), .i_sck(sck), .i_ws(ws),
        .i_left(left32), .i_right(right32), .i_valid(valid32), .o_ready(ready32),
        .i_mute(mute32), .o_sd(sd32), .o_underrun(underrun32)
    );

    int    ncmp = 0;
    int    nerr = 0;
    src_t  mode;
    int    cnt;
    int    ph, bitcnt;
    bit    m_sck_q, m_ws_q, m_full, m_mute;
    logic [DW-1:0] m_left, m_right;
    logic [31:0]   m_rreg, hist, hist32, exp_cur, exp_next;
    bit    exp_valid, exp_ur, ev_fall, ev_chg, ev_ws, lstart, lstart_seen;
    bit    ph32, armed32;
    int    n32;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        ncmp++;
        assert (got === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] justify(input logic [DW-1:0] s);
        return {s, 8'h00};
    endfunction

    // One i_clk cycle: model the coming edge, check outputs, then drive the next cycle.
    task tick();
        bit acc;
        @(posedge i_clk);
        acc = 0; ev_fall = 0; ev_chg = 0; exp_ur = 0; lstart = 0;
        if (rst) begin
            m_sck_q = 0; m_ws_q = 0; m_full = 0; m_rreg = '0;
            exp_valid = 0; hist = '0; hist32 = '0;
        end else begin
            acc     = valid && !m_full;
            ev_fall = m_sck_q && !sck;
            m_sck_q = sck;
            if (ev_fall) begin
                ev_chg = (ws != m_ws_q);
                ev_ws  = ws;
                m_ws_q = ws;
                if (ev_chg && !ws) begin
                    lstart = 1; lstart_seen = 1;
                    if (m_full) begin
                        exp_next = m_mute ? 32'h0 : justify(m_left);
                        m_rreg   = m_mute ? 32'h0 : justify(m_right);
                        m_full   = 0;
                    end else begin
                        exp_next = '0; m_rreg = '0; exp_ur = 1;
                    end
                end else if (ev_chg) begin
                    exp_next = m_rreg;
                end
            end
            if (acc) begin
                m_full = 1; m_left = left; m_right = right; m_mute = mute;
            end
        end

        @(negedge i_clk);
        check("ready", 32'(ready), 32'(!m_full));
        check("underrun", 32'(underrun), 32'(exp_ur));
        if (rst) check("rst_sd", 32'(sd), 32'h0);
        if (ev_fall) begin
            hist   = {hist[30:0], sd};
            hist32 = {hist32[30:0], sd32};
            if (ev_chg) begin
                if (exp_valid) check(ev_ws ? "left_word" : "right_word", hist, exp_cur);
                exp_cur   = exp_next;
                exp_valid = 1;
            end
        end
        if (ph32) begin
            check("underrun32", 32'(underrun32), 32'h0);
            check("ready32", 32'(ready32), 32'(lstart));
            if (ev_fall && ev_chg) begin
                if (ev_ws && armed32) begin
                    check("lsb32", 32'(sd32), 32'h1);
                    check("left_word32", hist32, 32'hFFFF_FFFF);
                    n32++;
                end else if (!ev_ws && armed32) begin
                    check("right_word32", hist32, 32'h0);
                end
                if (!ev_ws) armed32 = 1;
            end
        end

        // Upstream source behaviour.
        if (acc && mode == SRC_ONCE) valid = 0;
        if (acc && mode == SRC_COUNT) begin
            cnt++;
            left  = 24'(cnt);
            right = 24'(cnt) + 24'h10_0000;
        end
        if (mode == SRC_RAND && (acc || !valid)) begin
            valid = ($urandom_range(3) == 0);
            left  = 24'($urandom);
            right = 24'($urandom);
            mute  = ($urandom_range(7) == 0);
        end

        // Bit-clock generator: sck period SCK_DIV, ws toggles on every SW-th falling edge.
        ph++;
        sck = ((ph % SCK_DIV) < 2);
        if ((ph % SCK_DIV) == 2) begin
            bitcnt++;
            if (bitcnt == SW) begin
                bitcnt = 0;
                ws = ~ws;
            end
        end
    endtask

    task run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task present(input logic [DW-1:0] l, input logic [DW-1:0] r, input logic m);
        mode = SRC_ONCE; left = l; right = r; mute = m; valid = 1;
    endtask

    initial begin
        rst = 1; ph = 0; bitcnt = 0; sck = 1; ws = 0;
        valid = 0; mute = 0; left = '0; right = '0; mode = SRC_IDLE; cnt = 0;
        left32 = 32'hFFFF_FFFF; right32 = 32'h0; valid32 = 1; mute32 = 0;
        ph32 = 0; armed32 = 0; n32 = 0; lstart_seen = 0;
        m_sck_q = 0; m_ws_q = 0; m_full = 0; m_mute = 0; m_left = '0; m_right = '0;
        m_rreg = '0; hist = '0; hist32 = '0; exp_cur = '0; exp_next = '0; exp_valid = 0;
        run(3);
        rst = 0;

        // Single frame, then silence.
        present(24'hA5A5A5, 24'h3C3C3C, 0);
        run(3 * FRAME_CLKS);

        // Continuous incrementing source: no underruns expected after the first slot.
        mode = SRC_COUNT; cnt = 1; left = 24'd1; right = 24'h10_0001; mute = 0; valid = 1;
        run(4 * FRAME_CLKS);

        // Starved source: underrun every frame, zeros on the line.
        mode = SRC_IDLE; valid = 0;
        run(3 * FRAME_CLKS);

        // Muted frame followed by a normal one.
        present(24'h800001, 24'h7FFFFF, 1);
        run(FRAME_CLKS + FRAME_CLKS / 2);
        present(24'h123456, 24'h654321, 0);
        run(2 * FRAME_CLKS);

        // Random frames with random gaps and occasional mute.
        mode = SRC_RAND; valid = 0;
        run(8 * FRAME_CLKS);

        // Reset in the middle of a right slot while another frame is held.
        present(24'h0F0F0F, 24'hFFFFFF, 0);
        for (int i = 0; i < 4 * FRAME_CLKS && valid; i++) tick();
        lstart_seen = 0;
        for (int i = 0; i < 2 * FRAME_CLKS && !lstart_seen; i++) tick();
        check("lstart_seen", 32'(lstart_seen), 32'h1);
        present(24'h555555, 24'hAAAAAA, 0);
        for (int i = 0; i < FRAME_CLKS && !(ws && bitcnt == 10); i++) tick();
        check("pre_rst_ready", 32'(ready), 32'h0);
        check("pre_rst_sd", 32'(sd), 32'h1);
        mode = SRC_IDLE; valid = 0;
        rst = 1;
        #1;
        check("async_rst_sd", 32'(sd), 32'h0);
        check("async_rst_ready", 32'(ready), 32'h1);
        run(3);
        rst = 0;
        run(2 * FRAME_CLKS);

        // Full-width build: all-ones left word, LSB on the right-slot ws edge.
        ph32 = 1; armed32 = 0;
        run(3 * FRAME_CLKS);
        check("frames32_seen", 32'(n32 >= 2), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
